// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU codes,
// enable/bus bit positions, T-state encoding and the decoded control bundle.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_INCPC = 5'd14;
    localparam logic [4:0] ALU_ADD   = 5'd15;
    localparam logic [4:0] ALU_SUB   = 5'd16;
    localparam logic [4:0] ALU_AND   = 5'd17;
    localparam logic [4:0] ALU_OR    = 5'd18;

    localparam int EN_ZIN   = 18;
    localparam int EN_YIN   = 19;
    localparam int EN_PCIN  = 20;
    localparam int EN_MDRIN = 21;
    localparam int EN_IRIN  = 24;
    localparam int EN_MARIN = 25;
    localparam int EN_CONIN = 27;

    localparam int BUS_ZLO    = 19;
    localparam int BUS_PC     = 20;
    localparam int BUS_MDR    = 21;
    localparam int BUS_INPORT = 22;
    localparam int BUS_C      = 23;

    typedef logic [3:0] tstep_t;
    localparam tstep_t T0 = 4'd0;
    localparam tstep_t T1 = 4'd1;
    localparam tstep_t T2 = 4'd2;
    localparam tstep_t T3 = 4'd3;
    localparam tstep_t T4 = 4'd4;
    localparam tstep_t T5 = 4'd5;
    localparam tstep_t T6 = 4'd6;
    localparam tstep_t T7 = 4'd7;

    typedef enum logic [1:0] {
        MODE_RESET = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_HALT  = 2'd2
    } mode_t;

    typedef struct packed {
        logic [31:0] enable;
        logic [31:0] bus_sel;
        logic [4:0]  alu;
        logic        gra;
        logic        grb;
        logic        grc;
        logic        rin;
        logic        rout;
        logic        baout;
        logic        md_read;
        logic        read_ram;
        logic        write_ram;
    } ctrl_t;

    // Final T-state of each instruction; anything unrecognised ends after fetch.
    function automatic tstep_t last_step(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: last_step = T5;
            OP_BR:                                          last_step = T6;
            OP_LD, OP_ST:                                   last_step = T7;
            OP_JR:                                          last_step = T3;
            default:                                        last_step = T2;
        endcase
    endfunction

    function automatic logic [4:0] alu_for(input logic [4:0] op);
        case (op)
            OP_SUB:  alu_for = ALU_SUB;
            OP_AND:  alu_for = ALU_AND;
            OP_OR:   alu_for = ALU_OR;
            default: alu_for = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_step_decode.sv
// Combinational decode of (opcode, T-state, branch condition) into the
// datapath control bundle. Every field not named for a state stays 0.
module control_step_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    input  tstep_t     step,
    input  logic       conff,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (step)
            T0: begin
                ctrl.bus_sel[BUS_PC]  = 1'b1;
                ctrl.enable[EN_MARIN] = 1'b1;
                ctrl.alu              = ALU_INCPC;
                ctrl.enable[EN_ZIN]   = 1'b1;
            end
            T1: begin
                ctrl.bus_sel[BUS_ZLO] = 1'b1;
                ctrl.enable[EN_PCIN]  = 1'b1;
                ctrl.enable[EN_MDRIN] = 1'b1;
                ctrl.md_read          = 1'b1;
                ctrl.read_ram         = 1'b1;
            end
            T2: begin
                ctrl.bus_sel[BUS_MDR] = 1'b1;
                ctrl.enable[EN_IRIN]  = 1'b1;
            end
            default: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        case (step)
                            T3: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.enable[EN_YIN] = 1'b1; end
                            T4: begin
                                ctrl.grc = 1'b1; ctrl.rout = 1'b1;
                                ctrl.alu = alu_for(opcode); ctrl.enable[EN_ZIN] = 1'b1;
                            end
                            T5: begin ctrl.bus_sel[BUS_ZLO] = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    // Immediate forms share the base+offset address computation.
                    OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
                        case (step)
                            T3: begin ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.enable[EN_YIN] = 1'b1; end
                            T4: begin
                                ctrl.bus_sel[BUS_C] = 1'b1; ctrl.alu = ALU_ADD;
                                ctrl.enable[EN_ZIN] = 1'b1;
                            end
                            T5: begin
                                ctrl.bus_sel[BUS_ZLO] = 1'b1;
                                if (opcode == OP_LD || opcode == OP_ST) begin
                                    ctrl.enable[EN_MARIN] = 1'b1;
                                end else begin
                                    ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                                end
                            end
                            T6: begin
                                ctrl.enable[EN_MDRIN] = 1'b1;
                                if (opcode == OP_LD) begin
                                    ctrl.md_read = 1'b1; ctrl.read_ram = 1'b1;
                                end else if (opcode == OP_ST) begin
                                    ctrl.gra = 1'b1; ctrl.rout = 1'b1;
                                end else begin
                                    ctrl.enable[EN_MDRIN] = 1'b0;
                                end
                            end
                            T7: begin
                                if (opcode == OP_LD) begin
                                    ctrl.bus_sel[BUS_MDR] = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                                end else if (opcode == OP_ST) begin
                                    ctrl.write_ram = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (step)
                            T3: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.enable[EN_CONIN] = 1'b1; end
                            T4: begin ctrl.bus_sel[BUS_PC] = 1'b1; ctrl.enable[EN_YIN] = 1'b1; end
                            T5: begin
                                ctrl.bus_sel[BUS_C] = 1'b1; ctrl.alu = ALU_ADD;
                                ctrl.enable[EN_ZIN] = 1'b1;
                            end
                            T6: if (conff) begin
                                ctrl.bus_sel[BUS_ZLO] = 1'b1; ctrl.enable[EN_PCIN] = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_JR: begin
                        if (step == T3) begin
                            ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.enable[EN_PCIN] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: owns the mode/T-state register and next-state
// logic, and gates the step decoder's output by the current mode.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int FETCH_STEPS = 3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        CONFFOut,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [4:0]  Control_Signals,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic        run
);

    localparam tstep_t FETCH_LAST = tstep_t'(FETCH_STEPS - 1);

    mode_t      mode;
    tstep_t     step;
    ctrl_t      dec;
    ctrl_t      ctrl;
    logic [4:0] opcode;
    logic       unused_ir_fields;

    assign opcode           = ir[31:27];
    assign unused_ir_fields = ^ir[26:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mode <= MODE_RESET;
            step <= T0;
        end else begin
            case (mode)
                MODE_RESET: begin
                    mode <= MODE_RUN;
                    step <= T0;
                end
                MODE_RUN: begin
                    if (step == FETCH_LAST && opcode == OP_HALT) begin
                        mode <= MODE_HALT;
                        step <= T0;
                    end else if (step >= last_step(opcode) || step >= T7) begin
                        step <= T0;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                MODE_HALT: ;
                default: begin
                    mode <= MODE_RESET;
                    step <= T0;
                end
            endcase
        end
    end

    control_step_decode u_decode (
        .opcode (opcode),
        .step   (step),
        .conff  (CONFFOut),
        .ctrl   (dec)
    );

    // Only a running sequencer drives the datapath; RESET and HALT are silent.
    assign ctrl = (mode == MODE_RUN) ? dec : '0;

    assign enable          = ctrl.enable;
    assign busSelect       = ctrl.bus_sel;
    assign Control_Signals = ctrl.alu;
    assign Gra             = ctrl.gra;
    assign Grb             = ctrl.grb;
    assign Grc             = ctrl.grc;
    assign Rin             = ctrl.rin;
    assign Rout            = ctrl.rout;
    assign BAout           = ctrl.baout;
    assign MD_Read         = ctrl.md_read;
    assign ReadRAM         = ctrl.read_ram;
    assign WriteRAM        = ctrl.write_ram;
    assign run             = (mode != MODE_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the driver queues the expected output
// vector for every cycle of each instruction; a negedge monitor pops and compares.
module tb_control_unit;

    localparam int W = 79;

    localparam logic [31:0] EN_Z   = 32'h0004_0000;
    localparam logic [31:0] EN_Y   = 32'h0008_0000;
    localparam logic [31:0] EN_PC  = 32'h0010_0000;
    localparam logic [31:0] EN_MDR = 32'h0020_0000;
    localparam logic [31:0] EN_IR  = 32'h0100_0000;
    localparam logic [31:0] EN_MAR = 32'h0200_0000;
    localparam logic [31:0] EN_CON = 32'h0800_0000;
    localparam logic [31:0] BS_ZLO = 32'h0008_0000;
    localparam logic [31:0] BS_PC  = 32'h0010_0000;
    localparam logic [31:0] BS_MDR = 32'h0020_0000;
    localparam logic [31:0] BS_C   = 32'h0080_0000;

    localparam logic [8:0] F_NONE = 9'h000;
    localparam logic [8:0] F_GRA  = 9'h100;
    localparam logic [8:0] F_GRB  = 9'h080;
    localparam logic [8:0] F_GRC  = 9'h040;
    localparam logic [8:0] F_RIN  = 9'h020;
    localparam logic [8:0] F_ROUT = 9'h010;
    localparam logic [8:0] F_BA   = 9'h008;
    localparam logic [8:0] F_MDRD = 9'h004;
    localparam logic [8:0] F_RD   = 9'h002;
    localparam logic [8:0] F_WR   = 9'h001;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        conff;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [4:0]  Control_Signals;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        MD_Read, ReadRAM, WriteRAM, run;

    control_unit #(.FETCH_STEPS(3)) dut (
        .clk             (clk),
        .clr             (clr),
        .ir              (ir),
        .CONFFOut        (conff),
        .enable          (enable),
        .busSelect       (busSelect),
        .Control_Signals (Control_Signals),
        .Gra             (Gra),
        .Grb             (Grb),
        .Grc             (Grc),
        .Rin             (Rin),
        .Rout            (Rout),
        .BAout           (BAout),
        .MD_Read         (MD_Read),
        .ReadRAM         (ReadRAM),
        .WriteRAM        (WriteRAM),
        .run             (run)
    );

    // Clock and reset: 10-time-unit period; clr is driven by the stimulus process.
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] mon_exp;
    string        mon_name;
    logic [W-1:0] act;

    assign act = {run, enable, busSelect, Control_Signals,
                  Gra, Grb, Grc, Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM};

    function automatic logic [W-1:0] v(input logic r, input logic [31:0] en,
                                       input logic [31:0] bus, input logic [4:0] alu,
                                       input logic [8:0] f);
        return {r, en, bus, alu, f};
    endfunction

    localparam logic [W-1:0] RST_V  = {1'b1, 78'b0};
    localparam logic [W-1:0] HALT_V = {W{1'b0}};

    // Driver tasks
    task automatic expect_v(input logic [W-1:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic advance(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [31:0] i, input logic c, input string tag);
        ir    = i;
        conff = c;
        expect_v(v(1'b1, EN_MAR | EN_Z, BS_PC, 5'd14, F_NONE), {tag, ".T0"});
        expect_v(v(1'b1, EN_PC | EN_MDR, BS_ZLO, 5'd0, F_MDRD | F_RD), {tag, ".T1"});
        expect_v(v(1'b1, EN_IR, BS_MDR, 5'd0, F_NONE), {tag, ".T2"});
    endtask

    task automatic alu_instr(input logic [31:0] i, input logic [4:0] alu, input string tag);
        start(i, 1'b0, tag);
        expect_v(v(1'b1, EN_Y, 32'h0, 5'd0, F_GRB | F_ROUT), {tag, ".T3"});
        expect_v(v(1'b1, EN_Z, 32'h0, alu, F_GRC | F_ROUT), {tag, ".T4"});
        expect_v(v(1'b1, 32'h0, BS_ZLO, 5'd0, F_GRA | F_RIN), {tag, ".T5"});
        advance(6);
    endtask

    task automatic addr_calc(input string tag);
        expect_v(v(1'b1, EN_Y, 32'h0, 5'd0, F_GRB | F_BA), {tag, ".T3"});
        expect_v(v(1'b1, EN_Z, BS_C, 5'd15, F_NONE), {tag, ".T4"});
    endtask

    task automatic imm_instr(input logic [31:0] i, input string tag);
        start(i, 1'b0, tag);
        addr_calc(tag);
        expect_v(v(1'b1, 32'h0, BS_ZLO, 5'd0, F_GRA | F_RIN), {tag, ".T5"});
        advance(6);
    endtask

    task automatic mem_head(input logic [31:0] i, input string tag);
        start(i, 1'b0, tag);
        addr_calc(tag);
        expect_v(v(1'b1, EN_MAR, BS_ZLO, 5'd0, F_NONE), {tag, ".T5"});
    endtask

    task automatic ld_instr(input logic [31:0] i, input string tag);
        mem_head(i, tag);
        expect_v(v(1'b1, EN_MDR, 32'h0, 5'd0, F_MDRD | F_RD), {tag, ".T6"});
        expect_v(v(1'b1, 32'h0, BS_MDR, 5'd0, F_GRA | F_RIN), {tag, ".T7"});
        advance(8);
    endtask

    task automatic st_instr(input logic [31:0] i, input string tag);
        mem_head(i, tag);
        expect_v(v(1'b1, EN_MDR, 32'h0, 5'd0, F_GRA | F_ROUT), {tag, ".T6"});
        expect_v(v(1'b1, 32'h0, 32'h0, 5'd0, F_WR), {tag, ".T7"});
        advance(8);
    endtask

    task automatic br_instr(input logic [31:0] i, input logic c, input string tag);
        start(i, c, tag);
        expect_v(v(1'b1, EN_CON, 32'h0, 5'd0, F_GRA | F_ROUT), {tag, ".T3"});
        expect_v(v(1'b1, EN_Y, BS_PC, 5'd0, F_NONE), {tag, ".T4"});
        expect_v(v(1'b1, EN_Z, BS_C, 5'd15, F_NONE), {tag, ".T5"});
        if (c) expect_v(v(1'b1, EN_PC, BS_ZLO, 5'd0, F_NONE), {tag, ".T6"});
        else   expect_v(v(1'b1, 32'h0, 32'h0, 5'd0, F_NONE), {tag, ".T6"});
        advance(7);
    endtask

    task automatic jr_instr(input logic [31:0] i, input string tag);
        start(i, 1'b0, tag);
        expect_v(v(1'b1, EN_PC, 32'h0, 5'd0, F_GRA | F_ROUT), {tag, ".T3"});
        advance(4);
    endtask

    task automatic fetch_only(input logic [31:0] i, input string tag);
        start(i, 1'b0, tag);
        advance(3);
    endtask

    // Scoreboard monitor plus per-cycle invariants
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            checks++;
            if (act !== mon_exp) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", mon_name, act, mon_exp);
            end
        end
        checks++;
        if (!$onehot0(busSelect) || (Rin && Rout) || (ReadRAM && WriteRAM)) begin
            failures++;
            $display("FAIL invariant busSelect=%h Rin=%b Rout=%b ReadRAM=%b WriteRAM=%b",
                     busSelect, Rin, Rout, ReadRAM, WriteRAM);
        end
    end

    initial begin
        clr   = 1'b0;
        ir    = 32'h0;
        conff = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) expect_v(RST_V, "reset_hold");
        advance(3);
        clr = 1'b1;
        expect_v(RST_V, "reset_release");
        advance(1);

        alu_instr(32'h1988_8000, 5'd15, "add");
        alu_instr(32'h2188_8000, 5'd16, "sub");
        alu_instr(32'h2988_8000, 5'd17, "and");
        alu_instr(32'h3188_8000, 5'd18, "or");
        imm_instr(32'h0880_0005, "ldi");
        imm_instr(32'h6100_0003, "addi");
        ld_instr(32'h0100_0055, "ld");
        st_instr(32'h1100_0055, "st");
        br_instr(32'h9300_0023, 1'b1, "br_taken");
        br_instr(32'h9300_0023, 1'b0, "br_not_taken");
        jr_instr(32'hA180_0000, "jr");
        fetch_only(32'hD000_0000, "nop");
        fetch_only(32'hF800_0000, "undef");

        // Abort a load in T6: outputs must drop before the next edge.
        mem_head(32'h0100_0055, "ld_abort");
        advance(6);
        #2;
        clr = 1'b0;
        expect_v(RST_V, "ld_abort.clr");
        advance(1);
        clr = 1'b1;
        expect_v(RST_V, "ld_abort.release");
        advance(1);
        ld_instr(32'h0100_0055, "ld_restart");

        start(32'hD800_0000, 1'b0, "halt");
        repeat (20) expect_v(HALT_V, "halt.hold");
        advance(23);
        clr = 1'b0;
        expect_v(RST_V, "halt.clr");
        advance(1);
        clr = 1'b1;
        expect_v(RST_V, "halt.release");
        advance(1);
        fetch_only(32'hD000_0000, "post_halt_nop");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
